// File: rtl/spi_slave_fe_p_pkg.sv
// Shared types and defaults for the parametrised SPI slave front end.
package spi_slave_fe_p_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Bit-counter width able to index every bit of a word.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_fe_p_sync.sv
// Single-bit multi-stage synchroniser with a synchronous reset value.
module spi_slave_fe_p_sync
    import spi_slave_fe_p_pkg::*;
#(
    parameter int unsigned STAGES  = DEF_SYNC_STAGES,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_fe_p.sv
// SPI slave front end: pin synchronisation, CPOL/CPHA edge decode, burst RX/TX with handshakes.
// Define SPI_FE_ECHO_EN to transmit the last received word when the TX holding register is empty.
module spi_slave_fe_p
    import spi_slave_fe_p_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              ss_pos_edge,
    output logic              ss_neg_edge,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    logic sclk_s, ss_s, mosi_s;

    spi_slave_fe_p_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s)
    );
    spi_slave_fe_p_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d_i(ss), .q_o(ss_s)
    );
    spi_slave_fe_p_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s)
    );

    // Edge decode against one history flop; pulses are registered with mosi kept aligned.
    logic sclk_h_q, ss_h_q;
    logic sample_q, shift_q, mosi_q, ss_pos_q, ss_neg_q;
    logic sclk_rise_c, sclk_fall_c, lead_c, trail_c;

    assign sclk_rise_c = sclk_s & ~sclk_h_q;
    assign sclk_fall_c = ~sclk_s & sclk_h_q;
    assign lead_c      = (CPOL == 0) ? sclk_rise_c : sclk_fall_c;
    assign trail_c     = (CPOL == 0) ? sclk_fall_c : sclk_rise_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_h_q <= 1'(CPOL);
            ss_h_q   <= 1'b1;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            mosi_q   <= 1'b0;
            ss_pos_q <= 1'b0;
            ss_neg_q <= 1'b0;
        end else begin
            sclk_h_q <= sclk_s;
            ss_h_q   <= ss_s;
            sample_q <= (CPHA == 0) ? lead_c : trail_c;
            shift_q  <= (CPHA == 0) ? trail_c : lead_c;
            mosi_q   <= mosi_s;
            ss_pos_q <= ss_s & ~ss_h_q;
            ss_neg_q <= ~ss_s & ss_h_q;
        end
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              word_done_q, word_done_d;
    logic              skip_q, skip_d;

    logic [DATA_W-1:0] rx_next_c, tx_next_c, empty_c;
    logic              load_c, rx_done_c;

    assign rx_next_c = (MSB_FIRST != 0) ? {rx_shift_q[DATA_W-2:0], mosi_q}
                                        : {mosi_q, rx_shift_q[DATA_W-1:1]};
    assign tx_next_c = (MSB_FIRST != 0) ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                        : {1'b0, tx_shift_q[DATA_W-1:1]};
`ifdef SPI_FE_ECHO_EN
    assign empty_c = rx_data_q;
`else
    assign empty_c = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b1;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            word_done_q   <= 1'b0;
            skip_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            rx_data_q     <= rx_data_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            word_done_q   <= word_done_d;
            skip_q        <= skip_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = tx_ready_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        word_done_d   = word_done_q;
        skip_d        = skip_q;
        load_c        = 1'b0;
        rx_done_c     = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ss_neg_q) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    word_done_d = 1'b0;
                    // With CPHA=1 the first leading edge presents bit 0, already loaded here.
                    skip_d      = (CPHA != 0);
                    load_c      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_pos_q) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                    word_done_d = 1'b0;
                    skip_d      = 1'b0;
                end else begin
                    if (sample_q) begin
                        rx_shift_d = rx_next_c;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d   = '0;
                            rx_done_c   = 1'b1;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_q) begin
                        if (word_done_q) begin
                            load_c      = 1'b1;
                            word_done_d = 1'b0;
                        end else if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_shift_d = tx_next_c;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_done_c) begin
            rx_data_d    = rx_next_c;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q & ~rx_ready;
        end

        // Word start drains the holding register; an empty one substitutes the fill value.
        if (load_c) begin
            tx_shift_d    = tx_ready_q ? empty_c : hold_q;
            tx_underrun_d = tx_ready_q;
            tx_ready_d    = 1'b1;
        end

        if (tx_valid && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    assign miso        = (MSB_FIRST != 0) ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
    assign busy        = (state_q == ST_ACTIVE);
    assign miso_oe     = busy;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign ss_pos_edge = ss_pos_q;
    assign ss_neg_edge = ss_neg_q;

endmodule
